// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
// Round-robin arbiter that feeds 16-bit words from four requesting channels
// into a single SPI shift engine, one transfer at a time.
//
// Ports:
//   clk          system clock, shared with the SPI shift engine
//   rst          asynchronous, active-high reset
//   req_valid    per-channel request level
//   req_data     channel i word at [16i+15:16i]
//   req_ack      one-cycle pulse: channel i word captured
//   done         one-cycle pulse: channel i transfer finished
//   spi_start    start request to the shift engine
//   spi_data     word to the shift engine, stable for the whole transfer
//   spi_ready    shift engine idle (1) / busy (0)
//   busy         arbiter owns a transfer (REQ, XFER or GAP)
//   err_timeout  one-cycle pulse: engine never went busy after spi_start
//
// Parameters:
//   TIMEOUT_CYCLES  maximum REQ-state cycles waiting for spi_ready low
//   GAP_CYCLES      idle cycles enforced between transfers
module spi_tx_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd32,
    parameter logic [3:0] GAP_CYCLES     = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [63:0] req_data,
    output logic [3:0]  req_ack,
    output logic [3:0]  done,
    output logic        spi_start,
    output logic [15:0] spi_data,
    input  logic        spi_ready,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        GAP
    } state_t;

    state_t      state, state_n;
    logic [1:0]  last_grant, last_grant_n;
    logic [1:0]  cur_grant, cur_grant_n;
    logic [7:0]  tmo_cnt, tmo_cnt_n;
    logic [3:0]  gap_cnt, gap_cnt_n;
    logic [3:0]  req_ack_n;
    logic [3:0]  done_n;
    logic        spi_start_n;
    logic [15:0] spi_data_n;
    logic        busy_n;
    logic        err_timeout_n;

    logic        rr_found;
    logic [1:0]  rr_pick;
    logic [1:0]  rr_idx;

    // Round-robin search starting one past the last served channel; the
    // fourth step wraps back to last_grant itself so a lone requester that
    // was just served can still be granted again.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant;
        rr_idx   = last_grant;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_grant + i[1:0];
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the value each output register takes on the next edge.
    always_comb begin
        state_n       = state;
        last_grant_n  = last_grant;
        cur_grant_n   = cur_grant;
        tmo_cnt_n     = tmo_cnt;
        gap_cnt_n     = gap_cnt;
        req_ack_n     = 4'b0000;
        done_n        = 4'b0000;
        spi_start_n   = spi_start;
        spi_data_n    = spi_data;
        busy_n        = busy;
        err_timeout_n = 1'b0;

        case (state)
            IDLE: begin
                if (rr_found && spi_ready) begin
                    cur_grant_n        = rr_pick;
                    spi_data_n         = req_data[{rr_pick, 4'b0000} +: 16];
                    req_ack_n[rr_pick] = 1'b1;
                    spi_start_n        = 1'b1;
                    busy_n             = 1'b1;
                    tmo_cnt_n          = 8'd0;
                    state_n            = REQ;
                end
            end

            REQ: begin
                if (!spi_ready) begin
                    spi_start_n = 1'b0;
                    state_n     = XFER;
                end else if (tmo_cnt == TIMEOUT_CYCLES - 8'd1) begin
                    // Timed-out channel still counts as served, so a dead
                    // channel cannot block the others.
                    spi_start_n   = 1'b0;
                    err_timeout_n = 1'b1;
                    last_grant_n  = cur_grant;
                    gap_cnt_n     = 4'd0;
                    if (GAP_CYCLES == 4'd0) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = GAP;
                    end
                end else begin
                    tmo_cnt_n = tmo_cnt + 8'd1;
                end
            end

            XFER: begin
                if (spi_ready) begin
                    done_n[cur_grant] = 1'b1;
                    last_grant_n      = cur_grant;
                    gap_cnt_n         = 4'd0;
                    if (GAP_CYCLES == 4'd0) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = GAP;
                    end
                end
            end

            GAP: begin
                if (gap_cnt == GAP_CYCLES - 4'd1) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    gap_cnt_n = gap_cnt + 4'd1;
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers. last_grant resets to 3 so channel 0 is
    // the first to be considered after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 2'd3;
            cur_grant   <= 2'd0;
            tmo_cnt     <= 8'd0;
            gap_cnt     <= 4'd0;
            req_ack     <= 4'b0000;
            done        <= 4'b0000;
            spi_start   <= 1'b0;
            spi_data    <= 16'h0000;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            cur_grant   <= cur_grant_n;
            tmo_cnt     <= tmo_cnt_n;
            gap_cnt     <= gap_cnt_n;
            req_ack     <= req_ack_n;
            done        <= done_n;
            spi_start   <= spi_start_n;
            spi_data    <= spi_data_n;
            busy        <= busy_n;
            err_timeout <= err_timeout_n;
        end
    end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, 8 bits, default 8'd32, maximum REQ-state cycles waiting for spi_ready low; GAP_CYCLES, 4 bits, default 4'd2, idle cycles enforced between transfers.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  input  1  system clock, same clock as the SPI shift engine
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  4  per-channel transfer request, level
- req_data  input  64  channel i word at [16i+15:16i]
- req_ack  output  4  one-cycle pulse: channel i word captured
- done  output  4  one-cycle pulse: channel i transfer finished
- spi_start  output  1  start request to shift engine
- spi_data  output  16  word to shift engine, held stable for whole transfer
- spi_ready  input  1  shift engine idle (1) / busy (0)
- busy  output  1  arbiter owns a transfer
- err_timeout  output  1  one-cycle pulse: engine never went busy

Function
REQ-003 All outputs SHALL be registered; a single FSM SHALL use states IDLE, REQ, XFER, GAP.
REQ-004 IDLE: when any req_valid bit is 1 and spi_ready=1, the arbiter SHALL grant channel g chosen round-robin, searching last_grant+1, +2, +3, +4 (mod 4).
REQ-005 On the granting edge: spi_data<=req_data[g], req_ack[g]<=1, spi_start<=1, busy<=1, timeout counter<=0, state<=REQ.
REQ-006 IDLE with spi_ready=0 SHALL not grant, regardless of req_valid.
REQ-007 req_ack SHALL be high exactly one cycle per grant and one-hot; requester may change or drop req_data/req_valid after it.
REQ-008 REQ: spi_start SHALL stay 1 until spi_ready is sampled 0; on that edge spi_start<=0, state<=XFER.
REQ-009 REQ: each cycle with spi_ready=1 SHALL increment the timeout counter; when counter equals TIMEOUT_CYCLES-1 with spi_ready still 1: spi_start<=0, err_timeout<=1 for one cycle, no done pulse, state<=GAP.
REQ-010 XFER: when spi_ready is sampled 1: done[g]<=1 for one cycle, last_grant<=g, state<=GAP (or IDLE if GAP_CYCLES=0).
REQ-011 last_grant SHALL also update to g on timeout, so a failing channel cannot starve others.
REQ-012 GAP SHALL last exactly GAP_CYCLES cycles, then state<=IDLE, busy<=0 on that edge; no grant possible during GAP.
REQ-013 spi_data SHALL change only on a granting edge or reset.
REQ-014 Requests arriving during REQ/XFER/GAP SHALL be held pending by the requester (level) and arbitrated at next IDLE; none SHALL be dropped or double-acked.
REQ-015 At most one of done, err_timeout SHALL pulse per grant.

Reset
REQ-016 rst=1 SHALL asynchronously force: state IDLE, spi_start 0, spi_data 16'h0000, req_ack 0, done 0, busy 0, err_timeout 0, last_grant 3 (channel 0 first), counters 0.
REQ-017 Reset mid-transfer SHALL abort without done/err pulse; first grant after release SHALL follow REQ-004 from last_grant=3.

Verification
REQ-018 Single request: req_valid=4'b0100, data ch2=16'hA5C3, engine model busy 18 cycles -> req_ack=4'b0100 and spi_start same cycle, engine receives 16'hA5C3, done=4'b0100 one cycle after spi_ready returns, busy low GAP_CYCLES=2 cycles later.
REQ-019 All four requesting continuously -> grants in order 0,1,2,3,0; exactly one req_ack and one done per transfer; ≥2 idle cycles between spi_ready high and next spi_start.
REQ-020 Engine model holds spi_ready=1 forever -> spi_start high exactly 32 cycles, err_timeout one pulse, no done, next grant goes to next channel.
REQ-021 spi_ready=0 at request time -> no grant until spi_ready=1; then grant on next edge.
REQ-022 rst asserted during XFER -> all outputs at reset values immediately, no done; after release with req_valid=4'b1010 first grant is channel 1.
